// File: rtl/ram_wr.sv
// ram_wr -- frame writer for a single-buffer RAM hand-off.
//
// Writes one frame of DEPTH words into RAM at addresses 0..DEPTH-1. Each
// word is (frame_cnt + addr) mod 2^DATA_W. The writer then raises
// buf_valid and waits for the reader to pulse rd_done. It counts every
// consumed frame and then either returns to idle or, with mode_cont=1,
// starts the next frame after exactly one idle cycle.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start        request one frame write (acted on only in IDLE)
//   mode_cont    continuous framing, no start needed
//   abort        synchronous cancel of the current frame (highest priority)
//   rd_done      one-cycle pulse from the reader: buffer consumed
//   ram_wr_en    RAM write enable (registered)
//   ram_wr_addr  RAM write address, 0 whenever ram_wr_en=0 (registered)
//   ram_wr_data  RAM write data (registered)
//   buf_valid    complete frame in RAM, not yet consumed (registered)
//   busy         FSM not in IDLE (decoded from the state register)
//   frame_cnt    completed-and-consumed frame counter, wraps 255->0
//   ovf_err      sticky: start seen while not IDLE, cleared only by rst
module ram_wr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_cont,
  input  logic              abort,
  input  logic              rd_done,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              buf_valid,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              ovf_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_next;

  assign addr_next = ram_wr_addr + ADDR_W'(1);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      buf_valid   <= 1'b0;
      frame_cnt   <= 8'd0;
      ovf_err     <= 1'b0;
    end else begin
      // Only a start sampled outside IDLE is an overrun; the start that
      // launches a frame is sampled while still in IDLE.
      if (start && (state_reg != IDLE)) begin
        ovf_err <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          ram_wr_en   <= 1'b0;
          ram_wr_addr <= '0;
          if (!abort && (start || mode_cont)) begin
            // The first word goes out on this edge, so addr 0 is visible
            // one cycle after start is sampled.
            state_reg   <= WRITE;
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= '0;
            ram_wr_data <= DATA_W'(frame_cnt);
          end
        end

        WRITE: begin
          if (abort) begin
            state_reg   <= IDLE;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            buf_valid   <= 1'b0;
          end else if (ram_wr_addr == LAST_ADDR) begin
            state_reg   <= WAIT_RD;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            buf_valid   <= 1'b1;
          end else begin
            // frame_cnt is cast to DATA_W (extend or truncate); the sum
            // wraps mod 2^DATA_W.
            ram_wr_addr <= addr_next;
            ram_wr_data <= DATA_W'(frame_cnt) + DATA_W'(addr_next);
          end
        end

        WAIT_RD: begin
          ram_wr_en   <= 1'b0;
          ram_wr_addr <= '0;
          if (abort) begin
            state_reg <= IDLE;
            buf_valid <= 1'b0;
          end else if (rd_done) begin
            state_reg <= IDLE;
            buf_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          ram_wr_en   <= 1'b0;
          ram_wr_addr <= '0;
          buf_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wr.sv
// tb_ram_wr -- self-checking bench for ram_wr.
// Directed steps run from a single initial block. Expected RAM writes
// (addr, data) are queued when a frame is launched. A negedge monitor
// pops one entry and compares it for every cycle with ram_wr_en=1.
module tb_ram_wr;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, mode_cont, abort, rd_done;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              buf_valid, busy, ovf_err;
  logic [7:0]        frame_cnt;

  int total = 0;
  int bad   = 0;

  // Each entry packs {addr[15:8], data[7:0]}.
  logic [15:0] exp_q[$];
  logic [7:0]  cnt_model;

  ram_wr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont),
    .abort(abort), .rd_done(rd_done), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .buf_valid(buf_valid), .busy(busy), .frame_cnt(frame_cnt),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] cnt, input int n);
    for (int a = 0; a < n; a++) begin
      logic [7:0] ea;
      logic [7:0] ed;
      ea = 8'(a);
      ed = cnt + ea;
      exp_q.push_back({ea, ed});
    end
  endtask

  // Start at addr 0 of a frame and advance 32 edges into WAIT_RD.
  // If ovf_at >= 0, start is pulsed while that address is on the bus.
  task automatic write_body(input int ovf_at);
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 0 || a == DEPTH - 1) chk("busy_in_write", 32'(busy), 32'd1);
      if (a == ovf_at) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  // Scoreboard consumer plus the "addr idles at 0" rule.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wr_en) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_write: got addr %0h want no write", ram_wr_addr);
        end
        if (exp_q.size() != 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_wr_addr), 32'(e[15:8]));
          chk("wr_data", 32'(ram_wr_data), 32'(e[7:0]));
        end
      end else begin
        chk("addr_idle_zero", 32'(ram_wr_addr), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode_cont = 1'b0; abort = 1'b0; rd_done = 1'b0;
    cnt_model = 8'd0;
    step(); step();
    chk("rst_en",   32'(ram_wr_en),   32'd0);
    chk("rst_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_data", 32'(ram_wr_data), 32'd0);
    chk("rst_bv",   32'(buf_valid),   32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_cnt",  32'(frame_cnt),   32'd0);
    chk("rst_ovf",  32'(ovf_err),     32'd0);
    rst = 1'b0;
    step();

    // Single frame: data 0x00..0x1F.
    push_frame(cnt_model, DEPTH);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_en",   32'(ram_wr_en),   32'd1);
    chk("first_addr", 32'(ram_wr_addr), 32'd0);
    write_body(-1);
    chk("eof_bv",   32'(buf_valid), 32'd1);
    chk("eof_en",   32'(ram_wr_en), 32'd0);
    chk("eof_busy", 32'(busy),      32'd1);
    chk("eof_q",    32'(exp_q.size()), 32'd0);

    // Consume.
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cnt_model++;
    chk("cons_bv",   32'(buf_valid), 32'd0);
    chk("cons_cnt",  32'(frame_cnt), 32'(cnt_model));
    chk("cons_busy", 32'(busy),      32'd0);

    // Second frame: data 0x01..0x20.
    push_frame(cnt_model, DEPTH);
    start = 1'b1;
    step();
    start = 1'b0;
    write_body(-1);
    chk("f2_bv", 32'(buf_valid), 32'd1);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cnt_model++;
    chk("f2_cnt", 32'(frame_cnt), 32'(cnt_model));

    // rd_done in IDLE is ignored.
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("idle_rd_cnt",  32'(frame_cnt), 32'(cnt_model));
    chk("idle_rd_busy", 32'(busy),      32'd0);

    // Abort at addr 10.
    push_frame(cnt_model, 11);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre_abort_addr", 32'(ram_wr_addr), 32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_en",   32'(ram_wr_en),   32'd0);
    chk("abort_addr", 32'(ram_wr_addr), 32'd0);
    chk("abort_bv",   32'(buf_valid),   32'd0);
    chk("abort_cnt",  32'(frame_cnt),   32'(cnt_model));
    chk("abort_busy", 32'(busy),        32'd0);

    // Abort in IDLE beats start.
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    step();
    chk("idle_abort_en", 32'(ram_wr_en), 32'd0);

    // Abort and rd_done together in WAIT_RD: count must not move.
    push_frame(cnt_model, DEPTH);
    start = 1'b1;
    step();
    start = 1'b0;
    write_body(-1);
    chk("ab_rd_bv_pre", 32'(buf_valid), 32'd1);
    abort = 1'b1; rd_done = 1'b1;
    step();
    abort = 1'b0; rd_done = 1'b0;
    chk("ab_rd_cnt",  32'(frame_cnt), 32'(cnt_model));
    chk("ab_rd_bv",   32'(buf_valid), 32'd0);
    chk("ab_rd_busy", 32'(busy),      32'd0);
    chk("ovf_clear",  32'(ovf_err),   32'd0);

    // Overrun: start pulsed at addr 5, frame completes untouched.
    push_frame(cnt_model, DEPTH);
    start = 1'b1;
    step();
    start = 1'b0;
    write_body(5);
    chk("ovf_set",   32'(ovf_err),   32'd1);
    chk("ovf_bv",    32'(buf_valid), 32'd1);
    chk("ovf_q",     32'(exp_q.size()), 32'd0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cnt_model++;
    chk("ovf_cnt",    32'(frame_cnt), 32'(cnt_model));
    chk("ovf_sticky", 32'(ovf_err),   32'd1);

    // Reset at addr 20: the addr 20 write is cut before the monitor sees it.
    push_frame(cnt_model, 20);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("pre_rst_addr", 32'(ram_wr_addr), 32'd20);
    rst = 1'b1;
    #1;
    chk("arst_en",   32'(ram_wr_en),   32'd0);
    chk("arst_addr", 32'(ram_wr_addr), 32'd0);
    chk("arst_data", 32'(ram_wr_data), 32'd0);
    chk("arst_busy", 32'(busy),        32'd0);
    chk("arst_cnt",  32'(frame_cnt),   32'd0);
    chk("arst_ovf",  32'(ovf_err),     32'd0);
    exp_q.delete();
    cnt_model = 8'd0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_en",   32'(ram_wr_en), 32'd0);
    chk("post_rst_busy", 32'(busy),      32'd0);

    // Continuous mode: 300 frames, rd_done 5 cycles after buf_valid.
    mode_cont = 1'b1;
    for (int f = 0; f < 300; f++) begin
      push_frame(cnt_model, DEPTH);
      step();
      chk("cont_addr0_en",   32'(ram_wr_en),   32'd1);
      chk("cont_addr0_addr", 32'(ram_wr_addr), 32'd0);
      write_body(-1);
      chk("cont_bv", 32'(buf_valid), 32'd1);
      repeat (5) step();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      cnt_model++;
      chk("cont_idle_busy", 32'(busy),      32'd0);
      chk("cont_cnt",       32'(frame_cnt), 32'(cnt_model));
    end
    chk("cont_wrap", 32'(frame_cnt), 32'd44);
    mode_cont = 1'b0;
    step();
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_q_empty",   32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_wr.md
RAM_WR -- requirements
Module: ram_wr

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 8, RAM data width.
- ADDR_W, default 5, RAM address width.
- DEPTH, default 32, words per frame, DEPTH <= 2^ADDR_W.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one frame write; sampled in IDLE only.
- mode_cont  in  1  1 = continuous framing without further start.
- abort  in  1  synchronous cancel of the current frame.
- rd_done  in  1  single-cycle pulse from the reader: buffer consumed.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- buf_valid  out  1  complete frame present in RAM, not yet consumed.
- busy  out  1  state != IDLE.
- frame_cnt  out  8  completed-and-consumed frame counter.
- ovf_err  out  1  sticky: start seen while not IDLE.

Function
REQ-003 All outputs SHALL be registered except busy, which is decoded from the state register.
REQ-004 The FSM SHALL have exactly three states: IDLE, WRITE, WAIT_RD.
REQ-005 IDLE transition: when (start | mode_cont) & !abort, the FSM SHALL go to WRITE on the next edge.
REQ-006 First write timing: in the first WRITE cycle, ram_wr_en=1, ram_wr_addr=0 and ram_wr_data=frame_cnt+0, i.e. one cycle after start is sampled.
REQ-007 WRITE progression: each WRITE cycle SHALL write one word; ram_wr_addr increments by 1 per cycle.
REQ-008 Write data SHALL be ram_wr_data = (frame_cnt + ram_wr_addr) mod 2^DATA_W, with frame_cnt zero-extended or truncated to DATA_W.
REQ-009 End of frame: after the cycle with ram_wr_addr=DEPTH-1, the FSM SHALL enter WAIT_RD. On that next edge: ram_wr_en=0, ram_wr_addr=0, buf_valid=1.
REQ-010 ram_wr_en SHALL be 1 only in WRITE; exactly DEPTH consecutive write cycles per uninterrupted frame.
REQ-011 ram_wr_addr SHALL hold 0 whenever ram_wr_en=0.
REQ-012 WAIT_RD exit: on rd_done=1 & !abort, the FSM SHALL go to IDLE; on that edge buf_valid=0 and frame_cnt increments, wrapping 255->0.
REQ-013 Ignored rd_done: rd_done outside WAIT_RD SHALL have no effect.
REQ-014 Continuous mode: with mode_cont=1, the FSM SHALL spend exactly one cycle in IDLE between frames, so the next frame's addr 0 is written two cycles after rd_done.
REQ-015 Start while busy: start asserted while not IDLE SHALL be ignored and SHALL set ovf_err=1; ovf_err clears only on rst.
REQ-016 Abort in WRITE or WAIT_RD: on the next edge the FSM SHALL go to IDLE with ram_wr_en=0, ram_wr_addr=0, buf_valid=0, and frame_cnt unchanged.
REQ-017 Abort priority: abort SHALL win over start, mode_cont and rd_done in the same cycle.
REQ-018 Abort in IDLE SHALL hold IDLE, even with start=1.
REQ-019 start held high across the IDLE->WRITE edge SHALL NOT set ovf_err; only start sampled while state != IDLE counts.

Reset
REQ-020 rst=1 SHALL asynchronously force:
- state=IDLE
- ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0
- buf_valid=0, frame_cnt=0, ovf_err=0

REQ-021 Reset mid-frame SHALL abandon the partial frame; no write SHALL occur on the first edge after rst deasserts.
REQ-022 After rst deasserts, operation SHALL resume from IDLE on the first clk edge.

Verification
REQ-023 Single frame: start pulse after reset -> addrs 0..31 on 32 consecutive cycles with data 0x00..0x1F; buf_valid=1 the following cycle; busy=1 throughout.
REQ-024 Consume: rd_done pulse in WAIT_RD -> next cycle buf_valid=0, frame_cnt=1, busy=0; a second start writes data 0x01..0x20.
REQ-025 Continuous run: mode_cont=1, rd_done returned 5 cycles after each buf_valid, 300 frames -> frame_cnt wraps 255->0; exactly 1 idle cycle between rd_done+1 and the next addr 0; data equals (frame_cnt+addr) mod 256 on every write.
REQ-026 Abort at addr 10 -> next cycle ram_wr_en=0, ram_wr_addr=0, buf_valid=0, frame_cnt unchanged; abort+rd_done in the same WAIT_RD cycle -> frame_cnt unchanged.
REQ-027 Overrun: start pulsed at addr 5 -> frame completes unaffected and ovf_err=1 stays set until rst.
REQ-028 Reset mid-frame at addr 20 -> all outputs 0 immediately (asynchronous); no ram_wr_en after release until a new start.
